riscv_regfile: RTL and testbench

//  Integer register file at the receiving end of the writeback interface: accepts
//  rf_w_* writes from the WBU and serves two source-operand reads to decode.

---
 rtl/riscv_regfile.sv | 129 ++++++++++++
 tb/tb_riscv_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile.sv
// Integer register file: registered dual read, single write, with a post-reset zero sweep.
// Define RISCV_RF_BYPASS_EN for write-first same-edge collisions; the default build is read-first.
module riscv_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    output logic            ready_o,
    input  logic            rd_en_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            rf_w_enable_i,
    input  logic [4:0]      rf_w_addr_i,
    input  logic [XLEN-1:0] rf_w_data_i
);

    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;

    logic [XLEN-1:0]   mem_q [NUM_REGS];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [XLEN-1:0]   mem_wdata;

    logic              wr_ok;
    logic              rs1_valid, rs2_valid;
    logic              rs1_hit, rs2_hit;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    // x0 and indices beyond the implemented file are architecturally hard zero
    function automatic logic idx_valid(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < 6'(NUM_REGS));
    endfunction

    assign wr_ok     = rf_w_enable_i && idx_valid(rf_w_addr_i);
    assign rs1_valid = idx_valid(rs1_addr_i);
    assign rs2_valid = idx_valid(rs2_addr_i);

`ifdef RISCV_RF_BYPASS_EN
    assign rs1_hit = wr_ok && (rf_w_addr_i == rs1_addr_i);
    assign rs2_hit = wr_ok && (rf_w_addr_i == rs2_addr_i);
`else
    assign rs1_hit = 1'b0;
    assign rs2_hit = 1'b0;
`endif

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_valid) begin
            rs1_val = rs1_hit ? rf_w_data_i : mem_q[rs1_addr_i[IDX_W-1:0]];
        end
        if (rs2_valid) begin
            rs2_val = rs2_hit ? rf_w_data_i : mem_q[rs2_addr_i[IDX_W-1:0]];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = rf_w_addr_i[IDX_W-1:0];
        mem_wdata  = rf_w_data_i;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        case (state_q)
            ST_INIT: begin
                // entry 0 is never swept: it is never read back from the array
                mem_we     = 1'b1;
                mem_waddr  = cnt_q;
                mem_wdata  = '0;
                cnt_d      = cnt_q + IDX_W'(1);
                rs1_data_d = '0;
                rs2_data_d = '0;
                if (cnt_q == IDX_W'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_we = wr_ok;
                if (rd_en_i) begin
                    rs1_data_d = rs1_val;
                    rs2_data_d = rs2_val;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_INIT;
            cnt_q      <= IDX_W'(1);
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    // No reset on the array so it maps onto block RAM
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready_o    = (state_q == ST_RUN);
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed bench for riscv_regfile: a 32-entry and a 16-entry instance share stimulus,
// expected read data is queued when a cycle is driven and checked after the clock edge.
module tb_riscv_regfile;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        rd_en_i = 1'b0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rf_w_enable_i = 1'b0;
    logic [4:0]  rf_w_addr_i = '0;
    logic [31:0] rf_w_data_i = '0;

    logic        ready_32, ready_16;
    logic [31:0] rs1_32, rs2_32, rs1_16, rs2_16;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] e1_32;
        logic [31:0] e2_32;
        logic [31:0] e1_16;
        logic [31:0] e2_16;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [31:0] m32 [32];
    logic [31:0] m16 [16];

    always #5 clk_i = ~clk_i;

    riscv_regfile #(.XLEN(32), .NUM_REGS(32)) u_dut32 (
        .clk_i(clk_i), .reset_ni(reset_ni), .ready_o(ready_32),
        .rd_en_i(rd_en_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_32), .rs2_data_o(rs2_32),
        .rf_w_enable_i(rf_w_enable_i), .rf_w_addr_i(rf_w_addr_i), .rf_w_data_i(rf_w_data_i)
    );

    riscv_regfile #(.XLEN(32), .NUM_REGS(16)) u_dut16 (
        .clk_i(clk_i), .reset_ni(reset_ni), .ready_o(ready_16),
        .rd_en_i(rd_en_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_16), .rs2_data_o(rs2_16),
        .rf_w_enable_i(rf_w_enable_i), .rf_w_addr_i(rf_w_addr_i), .rf_w_data_i(rf_w_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m32[i] = '0;
        for (int i = 0; i < 16; i++) m16[i] = '0;
        last.tag   = "";
        last.e1_32 = '0;
        last.e2_32 = '0;
        last.e1_16 = '0;
        last.e2_16 = '0;
    endtask

    function automatic logic [31:0] rd32(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : m32[a];
    endfunction

    function automatic logic [31:0] rd16(input logic [4:0] a);
        return (a == 5'd0 || a >= 5'd16) ? 32'h0 : m16[a[3:0]];
    endfunction

    // One RUN-mode cycle: drive, predict, clock, compare
    task automatic cyc(input string tag, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit re,
                       input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        exp_t got;
        rf_w_enable_i = we;
        rf_w_addr_i   = wa;
        rf_w_data_i   = wd;
        rd_en_i       = re;
        rs1_addr_i    = a1;
        rs2_addr_i    = a2;
        if (re) begin
            e.e1_32 = rd32(a1);
            e.e2_32 = rd32(a2);
            e.e1_16 = rd16(a1);
            e.e2_16 = rd16(a2);
`ifdef RISCV_RF_BYPASS_EN
            if (we && wa != 5'd0) begin
                if (a1 == wa) e.e1_32 = wd;
                if (a2 == wa) e.e2_32 = wd;
                if (wa < 5'd16 && a1 == wa) e.e1_16 = wd;
                if (wa < 5'd16 && a2 == wa) e.e2_16 = wd;
            end
`endif
            last = e;
        end else begin
            e = last;
        end
        e.tag = tag;
        sb.push_back(e);
        if (we && wa != 5'd0) begin
            m32[wa] = wd;
            if (wa < 5'd16) m16[wa[3:0]] = wd;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        got = sb.pop_front();
        chk({got.tag, ".rs1_32"}, rs1_32, got.e1_32);
        chk({got.tag, ".rs2_32"}, rs2_32, got.e2_32);
        chk({got.tag, ".rs1_16"}, rs1_16, got.e1_16);
        chk({got.tag, ".rs2_16"}, rs2_16, got.e2_16);
        rf_w_enable_i = 1'b0;
        rd_en_i       = 1'b0;
    endtask

    // Assert reset at a negedge, check async effect, release two cycles later
    task automatic do_reset(input string tag);
        reset_ni = 1'b0;
        #1;
        chk({tag, ".ready_32"}, {31'd0, ready_32}, 32'd0);
        chk({tag, ".ready_16"}, {31'd0, ready_16}, 32'd0);
        chk({tag, ".rs1_32"}, rs1_32, 32'd0);
        chk({tag, ".rs2_32"}, rs2_32, 32'd0);
        chk({tag, ".rs1_16"}, rs1_16, 32'd0);
        chk({tag, ".rs2_16"}, rs2_16, 32'd0);
        clear_model();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    // Sweep of n edges; noisy drives writes/reads at x1 while both copies are still in INIT
    task automatic sweep(input string tag, input int n, input bit noisy);
        for (int i = 1; i <= n; i++) begin
            rf_w_enable_i = noisy && (i <= 15);
            rf_w_addr_i   = 5'd1;
            rf_w_data_i   = 32'hFFFF_FFFF;
            rd_en_i       = noisy && (i <= 15);
            rs1_addr_i    = 5'd1;
            rs2_addr_i    = 5'd2;
            @(posedge clk_i);
            @(negedge clk_i);
            chk($sformatf("%s.ready_32@%0d", tag, i), {31'd0, ready_32}, {31'd0, i >= 31});
            chk($sformatf("%s.ready_16@%0d", tag, i), {31'd0, ready_16}, {31'd0, i >= 15});
            if (noisy) begin
                chk($sformatf("%s.rs1_32@%0d", tag, i), rs1_32, 32'd0);
                chk($sformatf("%s.rs1_16@%0d", tag, i), rs1_16, 32'd0);
            end
        end
        rf_w_enable_i = 1'b0;
        rd_en_i       = 1'b0;
    endtask

    initial begin
        clear_model();
        @(negedge clk_i);
        do_reset("rst0");
        sweep("t1_sweep", 31, 1'b0);

        for (int i = 1; i < 32; i++) begin
            cyc("t1_zero", 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'((i + 1) % 32));
        end

        cyc("t2_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
        cyc("t2_rd", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);

        cyc("t3_wr_x0", 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
        cyc("t3_rd_x0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        cyc("t3_wr_x4", 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 5'd0);
        cyc("t3_wr_x20", 1'b1, 5'd20, 32'h0000_0001, 1'b0, 5'd0, 5'd0);
        cyc("t3_rd_x20_x4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd4);

        cyc("t4_wr_x7", 1'b1, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 5'd0);
        cyc("t4_collide", 1'b1, 5'd7, 32'h0000_0002, 1'b1, 5'd7, 5'd7);
        cyc("t4_reread", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);

        cyc("t5_rd_x3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd5);
        cyc("t5_hold0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd8, 5'd4);
        cyc("t5_hold1", 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd9, 5'd7);
        cyc("t5_hold2", 1'b0, 5'd0, 32'd0, 1'b0, 5'd10, 5'd5);
        cyc("t5_rd_new", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);

        cyc("t6_wr_x9", 1'b1, 5'd9, 32'h0000_00A5, 1'b0, 5'd0, 5'd0);
        cyc("t6_rd_x9", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
        do_reset("t6_rst_run");
        sweep("t6_part", 10, 1'b0);
        do_reset("t6_rst_init");
        sweep("t6_sweep", 31, 1'b1);
        cyc("t6_rd_x9_x1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd1);
        cyc("t6_rd_x5_x7", 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
